// File: rtl/wb_writer.sv
`default_nettype none
// ============================================================================
// Module      : wb_writer
// Description : Write-back stage of the pipelined MIPS core. Captures the
//               retiring M-stage instruction, formats the write-back value
//               (ALU, extended load data, link PC, HI, LO) and drives the
//               register-file write port plus a same-cycle forwarding port.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_writer #(
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter logic [31:0] LINK_OFFSET = 32'd8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m_valid,
   input  logic [31:0] m_pc,
   input  logic        m_we,
   input  logic [4:0]  m_aw,
   input  logic [2:0]  m_wsel,
   input  logic [31:0] m_alu,
   input  logic [31:0] m_dm_rdata,
   input  logic [2:0]  m_load_op,
   input  logic [1:0]  m_addr_lo,
   input  logic [31:0] m_hi,
   input  logic [31:0] m_lo,
   input  logic        w_stall,
   input  logic        w_flush,
   output logic        regWE,
   output logic [4:0]  regAW,
   output logic [31:0] regWD,
   output logic [31:0] w_pc,
   output logic        w_valid,
   output logic [4:0]  fwd_aw,
   output logic [31:0] fwd_wd,
   output logic        w_sel_err
);

   localparam logic [2:0] c_SEL_ALU  = 3'd0;
   localparam logic [2:0] c_SEL_LOAD = 3'd1;
   localparam logic [2:0] c_SEL_LINK = 3'd2;
   localparam logic [2:0] c_SEL_HI   = 3'd3;
   localparam logic [2:0] c_SEL_LO   = 3'd4;

   localparam logic [2:0] c_LD_LB    = 3'd1;
   localparam logic [2:0] c_LD_LBU   = 3'd2;
   localparam logic [2:0] c_LD_LH    = 3'd3;
   localparam logic [2:0] c_LD_LHU   = 3'd4;

   // W pipeline register
   logic        r_valid;
   logic [31:0] r_pc;
   logic        r_we;
   logic [4:0]  r_aw;
   logic [2:0]  r_wsel;
   logic [31:0] r_alu;
   logic [31:0] r_dm_rdata;
   logic [2:0]  r_load_op;
   logic [1:0]  r_addr_lo;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_sel_err;

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;
   logic [31:0] w_fmt_data;
   logic        w_reg_we;
   logic        w_capture;

   // A real instruction is taken only when neither flushed nor stalled
   assign w_capture = !w_flush && !w_stall && m_valid;

   // W register: flush beats stall, an invalid M slot loads a bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid    <= 1'b0;
         r_pc       <= RESET_PC;
         r_we       <= 1'b0;
         r_aw       <= 5'd0;
         r_wsel     <= 3'd0;
         r_alu      <= 32'd0;
         r_dm_rdata <= 32'd0;
         r_load_op  <= 3'd0;
         r_addr_lo  <= 2'd0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
      end else if (w_flush || (!w_stall && !m_valid)) begin
         r_valid    <= 1'b0;
         r_pc       <= RESET_PC;
         r_we       <= 1'b0;
         r_aw       <= 5'd0;
         r_wsel     <= 3'd0;
         r_alu      <= 32'd0;
         r_dm_rdata <= 32'd0;
         r_load_op  <= 3'd0;
         r_addr_lo  <= 2'd0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
      end else if (!w_stall) begin
         r_valid    <= 1'b1;
         r_pc       <= m_pc;
         r_we       <= m_we;
         r_aw       <= m_aw;
         r_wsel     <= m_wsel;
         r_alu      <= m_alu;
         r_dm_rdata <= m_dm_rdata;
         r_load_op  <= m_load_op;
         r_addr_lo  <= m_addr_lo;
         r_hi       <= m_hi;
         r_lo       <= m_lo;
      end
   end

   // Sticky flag for an illegal write source on a writing instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sel_err <= 1'b0;
      end else if (w_capture && m_we && (m_wsel > c_SEL_LO)) begin
         r_sel_err <= 1'b1;
      end
   end

   // Load extraction and write-data selection, driven only from W state
   always_comb begin
      w_byte      = 8'h00;
      w_half      = 16'h0000;
      w_load_data = r_dm_rdata;
      w_fmt_data  = 32'd0;

      case (r_addr_lo)
         2'd0:    w_byte = r_dm_rdata[7:0];
         2'd1:    w_byte = r_dm_rdata[15:8];
         2'd2:    w_byte = r_dm_rdata[23:16];
         default: w_byte = r_dm_rdata[31:24];
      endcase

      // addr_lo[0] is ignored: misaligned halfwords trap upstream
      w_half = r_addr_lo[1] ? r_dm_rdata[31:16] : r_dm_rdata[15:0];

      case (r_load_op)
         c_LD_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
         c_LD_LBU: w_load_data = {24'd0, w_byte};
         c_LD_LH:  w_load_data = {{16{w_half[15]}}, w_half};
         c_LD_LHU: w_load_data = {16'd0, w_half};
         default:  w_load_data = r_dm_rdata;
      endcase

      case (r_wsel)
         c_SEL_ALU:  w_fmt_data = r_alu;
         c_SEL_LOAD: w_fmt_data = w_load_data;
         c_SEL_LINK: w_fmt_data = r_pc + LINK_OFFSET;
         c_SEL_HI:   w_fmt_data = r_hi;
         c_SEL_LO:   w_fmt_data = r_lo;
         default:    w_fmt_data = 32'd0;
      endcase
   end

   // Writes to $0 and illegal sources are suppressed entirely
   assign w_reg_we  = r_valid && r_we && (r_aw != 5'd0) && (r_wsel <= c_SEL_LO);

   assign regWE     = w_reg_we;
   assign regAW     = w_reg_we ? r_aw : 5'd0;
   assign regWD     = w_reg_we ? w_fmt_data : 32'd0;
   assign fwd_aw    = regAW;
   assign fwd_wd    = regWD;
   assign w_pc      = r_pc;
   assign w_valid   = r_valid;
   assign w_sel_err = r_sel_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_writer
// Description : Self-checking bench for wb_writer: directed cases followed by
//               randomized traffic compared against a retirement-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_writer;

   localparam logic [31:0] c_RESET_PC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        m_valid;
   logic [31:0] m_pc;
   logic        m_we;
   logic [4:0]  m_aw;
   logic [2:0]  m_wsel;
   logic [31:0] m_alu;
   logic [31:0] m_dm_rdata;
   logic [2:0]  m_load_op;
   logic [1:0]  m_addr_lo;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic        w_stall;
   logic        w_flush;
   logic        regWE;
   logic [4:0]  regAW;
   logic [31:0] regWD;
   logic [31:0] w_pc;
   logic        w_valid;
   logic [4:0]  fwd_aw;
   logic [31:0] fwd_wd;
   logic        w_sel_err;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected architectural effect of the instruction currently in W
   logic        e_valid;
   logic [31:0] e_pc;
   logic        e_we;
   logic [4:0]  e_aw;
   logic [31:0] e_wd;
   logic        e_err;

   wb_writer #(.RESET_PC(32'h0000_3000), .LINK_OFFSET(32'd8)) dut (
      .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_we(m_we),
      .m_aw(m_aw), .m_wsel(m_wsel), .m_alu(m_alu), .m_dm_rdata(m_dm_rdata),
      .m_load_op(m_load_op), .m_addr_lo(m_addr_lo), .m_hi(m_hi), .m_lo(m_lo),
      .w_stall(w_stall), .w_flush(w_flush), .regWE(regWE), .regAW(regAW),
      .regWD(regWD), .w_pc(w_pc), .w_valid(w_valid), .fwd_aw(fwd_aw),
      .fwd_wd(fwd_wd), .w_sel_err(w_sel_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Value an instruction retires, straight from the ISA rules
   function automatic logic [31:0] ref_data(input logic [2:0] wsel, input logic [2:0] op,
                                            input logic [31:0] rd, input logic [1:0] alo,
                                            input logic [31:0] alu, input logic [31:0] pc,
                                            input logic [31:0] hi, input logic [31:0] lo);
      logic [31:0] b, h;
      b = (rd >> (8 * alo)) & 32'hFF;
      h = (rd >> (16 * alo[1])) & 32'hFFFF;
      case (wsel)
         3'd0: return alu;
         3'd1: begin
            case (op)
               3'd1:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
               3'd2:    return b;
               3'd3:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
               3'd4:    return h;
               default: return rd;
            endcase
         end
         3'd2: return pc + 32'd8;
         3'd3: return hi;
         3'd4: return lo;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_bubble();
      e_valid = 1'b0; e_pc = c_RESET_PC; e_we = 1'b0; e_aw = 5'd0; e_wd = 32'd0;
   endtask

   task automatic model_reset();
      model_bubble();
      e_err = 1'b0;
   endtask

   // Applies the inputs seen at a rising edge to the model
   task automatic model_edge();
      if (w_flush) begin
         model_bubble();
      end else if (!w_stall) begin
         if (!m_valid) begin
            model_bubble();
         end else begin
            e_valid = 1'b1;
            e_pc    = m_pc;
            e_we    = m_we && (m_aw != 0) && (m_wsel <= 4);
            e_aw    = e_we ? m_aw : 5'd0;
            e_wd    = e_we ? ref_data(m_wsel, m_load_op, m_dm_rdata, m_addr_lo,
                                      m_alu, m_pc, m_hi, m_lo) : 32'd0;
            if (m_we && m_wsel > 4) e_err = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, {31'd0, w_valid}, {31'd0, e_valid});
      chk({tag, ".pc"},    w_pc, e_pc);
      chk({tag, ".we"},    {31'd0, regWE}, {31'd0, e_we});
      chk({tag, ".aw"},    {27'd0, regAW}, {27'd0, e_aw});
      chk({tag, ".wd"},    regWD, e_wd);
      chk({tag, ".faw"},   {27'd0, fwd_aw}, {27'd0, e_aw});
      chk({tag, ".fwd"},   fwd_wd, e_wd);
      chk({tag, ".err"},   {31'd0, w_sel_err}, {31'd0, e_err});
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic set_m(input logic v, input logic [31:0] pc, input logic we,
                        input logic [4:0] aw, input logic [2:0] wsel, input logic [31:0] alu,
                        input logic [31:0] rd, input logic [2:0] op, input logic [1:0] alo,
                        input logic [31:0] hi, input logic [31:0] lo);
      m_valid = v; m_pc = pc; m_we = we; m_aw = aw; m_wsel = wsel; m_alu = alu;
      m_dm_rdata = rd; m_load_op = op; m_addr_lo = alo; m_hi = hi; m_lo = lo;
   endtask

   task automatic load_case(input logic [2:0] op, input logic [1:0] alo,
                            input logic [31:0] want, input string tag);
      set_m(1, 32'h3100, 1, 5'd10, 3'd1, 32'hAAAA_AAAA, 32'h80FF_7F01, op, alo, 0, 0);
      tick(tag);
      chk({tag, ".const"}, regWD, want);
   endtask

   // Reset pulse asserted between edges; outputs must clear without a clock
   task automatic async_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      chk({tag, ".pcconst"}, w_pc, 32'h0000_3000);
      @(posedge clk);
      #1;
      check_all({tag, "_hold"});
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; w_stall = 0; w_flush = 0;
      set_m(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("por");
      reset = 1'b0;

      // ALU write to $5 then asynchronous reset mid-operation
      set_m(1, 32'h3004, 1, 5'd5, 3'd0, 32'hCAFE_0005, 0, 0, 0, 0, 0);
      tick("alu5");
      async_reset("areset");

      set_m(1, 32'h3008, 1, 5'd8, 3'd0, 32'h1234_5678, 0, 0, 0, 0, 0);
      tick("alu8");
      chk("alu8.const", regWD, 32'h1234_5678);

      load_case(3'd1, 2'd3, 32'hFFFF_FF80, "lb3");
      load_case(3'd2, 2'd3, 32'h0000_0080, "lbu3");
      load_case(3'd3, 2'd2, 32'hFFFF_80FF, "lh2");
      load_case(3'd4, 2'd0, 32'h0000_7F01, "lhu0");
      load_case(3'd0, 2'd1, 32'h80FF_7F01, "lw");

      set_m(1, 32'h3010, 1, 5'd31, 3'd2, 0, 0, 0, 0, 0, 0);
      tick("link");
      chk("link.const", regWD, 32'h0000_3018);
      set_m(1, 32'h3010, 1, 5'd0, 3'd2, 0, 0, 0, 0, 0, 0);
      tick("link0");

      // mflo to $9, then hold while the M inputs change underneath
      set_m(1, 32'h3020, 1, 5'd9, 3'd4, 0, 0, 0, 0, 32'h1111_1111, 32'hDEAD_BEEF);
      tick("mflo");
      set_m(1, 32'h3024, 1, 5'd3, 3'd0, 32'h5555_5555, 0, 0, 0, 0, 0);
      w_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick("stall");
         chk("stall.const", regWD, 32'hDEAD_BEEF);
      end
      w_flush = 1'b1;
      tick("stflush");
      w_stall = 1'b0; w_flush = 1'b0;

      // Illegal source, then legal writes with the flag still raised
      set_m(1, 32'h3030, 1, 5'd7, 3'd6, 32'h7777_7777, 0, 0, 0, 0, 0);
      tick("illegal");
      chk("illegal.err", {31'd0, w_sel_err}, 32'd1);
      set_m(1, 32'h3034, 1, 5'd7, 3'd0, 32'h0000_0042, 0, 0, 0, 0, 0);
      tick("postill");
      tick("postill2");
      async_reset("errclr");

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         set_m(($urandom_range(0, 9) != 0), $urandom, $urandom_range(0, 3) != 0,
               5'($urandom_range(0, 31)),
               ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
               $urandom, $urandom, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
               $urandom, $urandom);
         w_stall = ($urandom_range(0, 4) == 0);
         w_flush = ($urandom_range(0, 9) == 0);
         tick("rand");
         if ($urandom_range(0, 99) == 0) async_reset("rreset");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
